// File: rtl/ip_exception_filter.sv
// ip_exception_filter
//   Inspects IPv4 headers on a 256-bit AXI4-Stream and steers packets arriving
//   from MAC ports that show an exception to the paired CPU port. The exceptions
//   are: short packet, non-IP, bad version, TTL<=1, or destination IP matching
//   a local-IP table entry. Packets from CPU ports are steered to the paired MAC.
//   Word0 is held in H until word1 arrives, because the destination IP spans
//   both words. Output register O drives the master port.
// Ports
//   AXI_ACLK / AXI_RESETN      : clock, asynchronous active-low reset
//   S_AXIS_*                   : input stream (slave)
//   M_AXIS_*                   : output stream (master), TUSER rewritten on word0
//   tbl_wr_* / tbl_rd_*        : local-IP table write / read access
//   drop_non_ip                : drop non-IP packets from MAC ports instead of steering
//   counter_clr                : synchronous clear of all exception counters
//   *_count                    : saturating 32-bit exception counters
module ip_exception_filter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24,
    parameter int NUM_PORTS            = 4,
    parameter int TBL_DEPTH            = 32,
    localparam int TBL_AW              = $clog2(TBL_DEPTH),
    localparam int KW                  = C_S_AXIS_DATA_WIDTH / 8
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic [KW-1:0]                   S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] S_AXIS_TUSER,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic [KW-1:0]                   M_AXIS_TSTRB,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    input  logic                            tbl_wr_req,
    input  logic [TBL_AW-1:0]               tbl_wr_addr,
    input  logic [31:0]                     tbl_wr_data,
    input  logic                            tbl_wr_valid,
    output logic                            tbl_wr_ack,
    input  logic                            tbl_rd_req,
    input  logic [TBL_AW-1:0]               tbl_rd_addr,
    output logic [31:0]                     tbl_rd_data,
    output logic                            tbl_rd_valid,
    output logic                            tbl_rd_ack,
    input  logic                            drop_non_ip,
    input  logic                            counter_clr,
    output logic [31:0]                     short_count,
    output logic [31:0]                     non_ip_count,
    output logic [31:0]                     ver_count,
    output logic [31:0]                     bad_ttl_count,
    output logic [31:0]                     dest_hit_count,
    output logic [31:0]                     dropped_count
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int PW = 2 * NUM_PORTS;
    localparam int IW = $clog2(PW);

    typedef enum logic [2:0] {IDLE, W1, FWD, DRAIN, DROP} state_t;
    state_t state, state_nxt;

    // hold (H) and output (O) registers
    logic [DW-1:0] h_data, o_data;
    logic [KW-1:0] h_strb, o_strb;
    logic [UW-1:0] h_user, o_user;
    logic          h_last, o_last, o_valid;

    // local-IP table
    logic [31:0] tbl_data [TBL_DEPTH];
    logic        tbl_vld  [TBL_DEPTH];

    logic [31:0] cnt [6];   // short, non_ip, ver, bad_ttl, dest_hit, dropped

    logic o_free, accept;
    assign o_free = !o_valid || M_AXIS_TREADY;
    assign accept = S_AXIS_TVALID && S_AXIS_TREADY;

    // ---------------- classification ----------------
    // In IDLE only a 1-beat packet is classified (word0 on the input); in W1 the
    // packet is classified with word0 from H and word1 on the input.
    logic [DW-1:0] cls_w0;
    logic [UW-1:0] cls_user, cls_user_new;
    logic [31:0]   dest_ip;
    logic          cls_short, cls_drop, tbl_hit, src_found;
    logic [IW-1:0] src_idx;
    logic [PW-1:0] src_bits, dst_bits;
    logic [5:0]    inc;

    assign cls_w0    = (state == IDLE) ? S_AXIS_TDATA : h_data;
    assign cls_user  = (state == IDLE) ? S_AXIS_TUSER : h_user;
    assign cls_short = (state == IDLE);
    assign dest_ip   = {cls_w0[15:0], S_AXIS_TDATA[DW-1:DW-16]};
    assign src_bits  = cls_user[SRC_PORT_POS +: PW];
    // paired port of either direction is the index with its LSB flipped
    assign dst_bits  = PW'(1) << (src_idx ^ IW'(1));

    always_comb begin
        tbl_hit = 1'b0;
        for (int i = 0; i < TBL_DEPTH; i++)
            if (tbl_vld[i] && tbl_data[i] == dest_ip) tbl_hit = 1'b1;
    end

    always_comb begin
        src_found = 1'b0;
        src_idx   = '0;
        // scan downwards so the lowest set bit wins
        for (int i = PW - 1; i >= 0; i--)
            if (src_bits[i]) begin
                src_found = 1'b1;
                src_idx   = IW'(i);
            end
    end

    always_comb begin
        logic steer;
        steer        = 1'b0;
        cls_drop     = 1'b0;
        inc          = '0;
        cls_user_new = cls_user;
        if (src_found) begin
            if (src_idx[0]) begin
                steer = 1'b1;                       // CPU -> paired MAC, no checks
            end else if (cls_short) begin
                inc[0] = 1'b1; steer = 1'b1;
            end else if (cls_w0[159:144] != 16'h0800) begin
                inc[1] = 1'b1;
                if (drop_non_ip) begin
                    cls_drop = 1'b1; inc[5] = 1'b1;
                end else begin
                    steer = 1'b1;
                end
            end else if (cls_w0[143:140] != 4'd4) begin
                inc[2] = 1'b1; steer = 1'b1;
            end else if (cls_w0[79:72] <= 8'd1) begin
                inc[3] = 1'b1; steer = 1'b1;
            end else if (tbl_hit) begin
                inc[4] = 1'b1; steer = 1'b1;
            end
        end
        if (steer) cls_user_new[DST_PORT_POS +: PW] = dst_bits;
    end

    // ---------------- FSM ----------------
    logic o_load, o_from_in, o_use_cls, h_load, cls_fire;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        o_load        = 1'b0;
        o_from_in     = 1'b0;
        o_use_cls     = 1'b0;
        h_load        = 1'b0;
        cls_fire      = 1'b0;
        S_AXIS_TREADY = o_free;
        case (state)
            IDLE: if (accept) begin
                if (S_AXIS_TLAST) begin
                    cls_fire = 1'b1; o_load = 1'b1; o_from_in = 1'b1; o_use_cls = 1'b1;
                end else begin
                    h_load = 1'b1; state_nxt = W1;
                end
            end
            W1: if (accept) begin
                cls_fire = 1'b1;
                if (cls_drop) begin
                    state_nxt = S_AXIS_TLAST ? IDLE : DROP;
                end else begin
                    o_load = 1'b1; o_use_cls = 1'b1; h_load = 1'b1;
                    state_nxt = S_AXIS_TLAST ? DRAIN : FWD;
                end
            end
            FWD: if (accept) begin
                o_load = 1'b1; h_load = 1'b1;
                if (S_AXIS_TLAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                S_AXIS_TREADY = 1'b0;
                if (o_free) begin
                    o_load = 1'b1; state_nxt = IDLE;
                end
            end
            DROP: begin
                S_AXIS_TREADY = 1'b1;
                if (accept && S_AXIS_TLAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            h_data <= '0; h_strb <= '0; h_user <= '0; h_last <= 1'b0;
            o_data <= '0; o_strb <= '0; o_user <= '0; o_last <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            if (o_valid && M_AXIS_TREADY) o_valid <= 1'b0;
            if (o_load) begin
                o_valid <= 1'b1;
                o_data  <= o_from_in ? S_AXIS_TDATA : h_data;
                o_strb  <= o_from_in ? S_AXIS_TSTRB : h_strb;
                o_last  <= o_from_in ? S_AXIS_TLAST : h_last;
                o_user  <= o_use_cls ? cls_user_new : h_user;
            end
            if (h_load) begin
                h_data <= S_AXIS_TDATA;
                h_strb <= S_AXIS_TSTRB;
                h_user <= S_AXIS_TUSER;
                h_last <= S_AXIS_TLAST;
            end
        end
    end

    assign M_AXIS_TVALID = o_valid;
    assign M_AXIS_TDATA  = o_data;
    assign M_AXIS_TSTRB  = o_strb;
    assign M_AXIS_TUSER  = o_user;
    assign M_AXIS_TLAST  = o_last;

    // ---------------- counters ----------------
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (counter_clr)                                   cnt[i] <= '0;
                else if (cls_fire && inc[i] && cnt[i] != '1)       cnt[i] <= cnt[i] + 32'd1;
            end
        end
    end

    assign short_count    = cnt[0];
    assign non_ip_count   = cnt[1];
    assign ver_count      = cnt[2];
    assign bad_ttl_count  = cnt[3];
    assign dest_hit_count = cnt[4];
    assign dropped_count  = cnt[5];

    // ---------------- local-IP table ----------------
    // Registered storage: a lookup or read in the write cycle sees the old entry.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_data[i] <= '0;
                tbl_vld[i]  <= 1'b0;
            end
            tbl_wr_ack   <= 1'b0;
            tbl_rd_ack   <= 1'b0;
            tbl_rd_data  <= '0;
            tbl_rd_valid <= 1'b0;
        end else begin
            tbl_wr_ack <= tbl_wr_req;
            tbl_rd_ack <= tbl_rd_req;
            if (tbl_wr_req) begin
                tbl_data[tbl_wr_addr] <= tbl_wr_data;
                tbl_vld[tbl_wr_addr]  <= tbl_wr_valid;
            end
            if (tbl_rd_req) begin
                tbl_rd_data  <= tbl_data[tbl_rd_addr];
                tbl_rd_valid <= tbl_vld[tbl_rd_addr];
            end
        end
    end

endmodule
